// File: rtl/wb_uart_debug_master_pkg.sv
// Shared codes and state encoding for the UART-driven Wishbone debug master.
// Optional ACK timeout is enabled by defining WB_DBG_TIMEOUT_EN.
package wb_uart_debug_master_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/wb_uart_debug_master.sv
// Byte-stream command decoder driving single Wishbone read/write cycles.
// Define WB_DBG_TIMEOUT_EN to abort unacknowledged cycles after TIMEOUT_CYCLES.
module wb_uart_debug_master
  import wb_uart_debug_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [7:0]            i_RX_DATA,
  input  logic                  i_RX_VALID,
  output logic [7:0]            o_TX_DATA,
  output logic                  o_TX_VALID,
  input  logic                  i_TX_READY,
  output logic [ADDR_WIDTH-1:0] o_WB_ADDR,
  output logic [DATA_WIDTH-1:0] o_WB_DATA,
  input  logic [DATA_WIDTH-1:0] i_WB_DATA,
  output logic                  o_WB_WE,
  output logic [3:0]            o_WB_SEL,
  output logic                  o_WB_STB,
  input  logic                  i_WB_ACK,
  output logic                  o_WB_CYC,
  output logic                  o_WB_TAGN,
  input  logic                  i_WB_TAGN,
  output logic                  o_BUSY,
  output logic                  o_DROP
);

  state_t                state;
  logic [7:0]            cmd;
  logic [1:0]            cnt;
  logic [DATA_WIDTH-1:0] rsp_sh;
  logic [1:0]            rsp_left;
  logic                  is_wr;
  logic                  unused_tagn;

  assign is_wr       = (cmd == CMD_WRITE);
  assign o_WB_SEL    = 4'hF;
  assign o_WB_TAGN   = 1'b1;
  assign unused_tagn = i_WB_TAGN;

`ifdef WB_DBG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= S_IDLE;
      cmd        <= 8'h00;
      cnt        <= 2'd0;
      rsp_sh     <= '0;
      rsp_left   <= 2'd0;
      o_TX_DATA  <= 8'h00;
      o_TX_VALID <= 1'b0;
      o_WB_ADDR  <= '0;
      o_WB_DATA  <= '0;
      o_WB_WE    <= 1'b0;
      o_WB_STB   <= 1'b0;
      o_WB_CYC   <= 1'b0;
      o_BUSY     <= 1'b0;
      o_DROP     <= 1'b0;
`ifdef WB_DBG_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      o_DROP <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_RX_VALID) begin
            cmd    <= i_RX_DATA;
            cnt    <= 2'd0;
            o_BUSY <= 1'b1;
            if (is_cmd(i_RX_DATA)) begin
              state <= S_ADDR;
            end else begin
              state      <= S_RESP;
              o_TX_VALID <= 1'b1;
              o_TX_DATA  <= RSP_NAK;
              rsp_left   <= 2'd0;
            end
          end
        end
        S_ADDR: begin
          if (i_RX_VALID) begin
            o_WB_ADDR <= {o_WB_ADDR[ADDR_WIDTH-9:0], i_RX_DATA};
            cnt       <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (is_wr) begin
                state <= S_WDATA;
              end else begin
                state    <= S_BUS;
                o_WB_CYC <= 1'b1;
                o_WB_STB <= 1'b1;
                o_WB_WE  <= 1'b0;
`ifdef WB_DBG_TIMEOUT_EN
                to_cnt   <= '0;
`endif
              end
            end
          end
        end
        S_WDATA: begin
          if (i_RX_VALID) begin
            o_WB_DATA <= {o_WB_DATA[DATA_WIDTH-9:0], i_RX_DATA};
            cnt       <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state    <= S_BUS;
              o_WB_CYC <= 1'b1;
              o_WB_STB <= 1'b1;
              o_WB_WE  <= 1'b1;
`ifdef WB_DBG_TIMEOUT_EN
              to_cnt   <= '0;
`endif
            end
          end
        end
        S_BUS: begin
          if (i_RX_VALID) o_DROP <= 1'b1;
          if (i_WB_ACK) begin
            state      <= S_RESP;
            o_WB_CYC   <= 1'b0;
            o_WB_STB   <= 1'b0;
            o_WB_WE    <= 1'b0;
            o_TX_VALID <= 1'b1;
            if (is_wr) begin
              o_TX_DATA <= RSP_ACK;
              rsp_left  <= 2'd0;
            end else begin
              o_TX_DATA <= i_WB_DATA[DATA_WIDTH-1 -: 8];
              rsp_sh    <= {i_WB_DATA[DATA_WIDTH-9:0], 8'h00};
              rsp_left  <= 2'd3;
            end
          end
`ifdef WB_DBG_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state      <= S_RESP;
            o_WB_CYC   <= 1'b0;
            o_WB_STB   <= 1'b0;
            o_WB_WE    <= 1'b0;
            o_TX_VALID <= 1'b1;
            o_TX_DATA  <= RSP_NAK;
            rsp_left   <= 2'd0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (i_RX_VALID) o_DROP <= 1'b1;
          if (o_TX_VALID && i_TX_READY) begin
            if (rsp_left == 2'd0) begin
              state      <= S_IDLE;
              o_TX_VALID <= 1'b0;
              o_BUSY     <= 1'b0;
            end else begin
              o_TX_DATA <= rsp_sh[DATA_WIDTH-1 -: 8];
              rsp_sh    <= {rsp_sh[DATA_WIDTH-9:0], 8'h00};
              rsp_left  <= rsp_left - 2'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
